// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a small registered ALU.
// One operation in flight at a time: accept in IDLE, compute in EXEC, hold in RESP.
module alu_arbiter #(
    parameter int word_size = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [1:0]           req0_op,
    input  logic [word_size-1:0] req0_a,
    input  logic [word_size-1:0] req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [1:0]           req1_op,
    input  logic [word_size-1:0] req1_a,
    input  logic [word_size-1:0] req1_b,
    output logic                 req1_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [word_size-1:0] result,
    output logic                 zero,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for a request; grants one requester combinationally
    // EXEC  | computing on the captured operands
    // RESP  | result presented until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    state_t               state;
    logic                 last_grant;
    logic                 cap_id;
    logic [1:0]           cap_op;
    logic [word_size-1:0] cap_a;
    logic [word_size-1:0] cap_b;

    logic                 grant_any;
    logic                 grant_id;
    logic                 grant_en;
    logic [word_size-1:0] alu_out;

    // With both valid the requester that did not win last time goes first.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    assign grant_en   = !rst && (state == IDLE) && grant_any;
    assign req0_ready = grant_en && !grant_id;
    assign req1_ready = grant_en && grant_id;
    assign busy       = (state != IDLE);

    always_comb begin
        alu_out = '0;
        case (cap_op)
            OP_ADD:  alu_out = cap_a + cap_b;
            OP_SUB:  alu_out = cap_a - cap_b;
            OP_AND:  alu_out = cap_a & cap_b;
            default: alu_out = cap_a | cap_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cap_id     <= 1'b0;
            cap_op     <= 2'b00;
            cap_a      <= '0;
            cap_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state      <= EXEC;
                        last_grant <= grant_id;
                        cap_id     <= grant_id;
                        cap_op     <= grant_id ? req1_op : req0_op;
                        cap_a      <= grant_id ? req1_a  : req0_a;
                        cap_b      <= grant_id ? req1_b  : req0_b;
                    end
                end
                EXEC: begin
                    state      <= RESP;
                    result     <= alu_out;
                    zero       <= (alu_out == '0);
                    resp_id    <= cap_id;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model
// (round-robin grant rule plus integer arithmetic modulo 2^16).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_ready, resp_id, zero, busy;
    logic [15:0] result;

    int   compared   = 0;
    int   mismatched = 0;
    logic exp_last;

    alu_arbiter #(.word_size(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_alu(input logic [1:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int r;
        case (op)
            2'd0:    r = (int'(a) + int'(b)) % 65536;
            2'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return r[15:0];
    endfunction

    task automatic scramble_inputs();
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
        req0_op = 2'($urandom); req1_op = 2'($urandom);
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom);
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic do_txn(input logic v0, input logic [1:0] o0, input logic [15:0] a0,
                          input logic [15:0] b0, input logic v1, input logic [1:0] o1,
                          input logic [15:0] a1, input logic [15:0] b1, input int stall);
        logic        g;
        logic [15:0] er;
        logic        ez;
        g  = (v0 && v1) ? !exp_last : v1;
        er = g ? model_alu(o1, a1, b1) : model_alu(o0, a0, b0);
        ez = (er == 16'h0);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        resp_ready = 1'b0;
        @(negedge clk);
        compared++;
        if ({req0_ready, req1_ready} !== {!g, g}) begin
            mismatched++;
            $display("FAIL grant: ready0/1 got %b%b want %b%b", req0_ready, req1_ready, !g, g);
        end
        @(posedge clk); #1;
        exp_last = g;
        scramble_inputs();
        @(negedge clk);
        compared++;
        if ({req0_ready, req1_ready, busy, resp_valid} !== 4'b0010) begin
            mismatched++;
            $display("FAIL exec: ready0/ready1/busy/resp_valid got %b%b%b%b want 0010",
                     req0_ready, req1_ready, busy, resp_valid);
        end
        @(posedge clk); #1;
        compared++;
        if (resp_valid !== 1'b1 || resp_id !== g || result !== er || zero !== ez) begin
            mismatched++;
            $display("FAIL resp: valid=%b id=%b result=%h zero=%b want 1 %b %h %b",
                     resp_valid, resp_id, result, zero, g, er, ez);
        end
        for (int i = 0; i < stall; i++) begin
            scramble_inputs();
            @(negedge clk);
            compared++;
            if (resp_valid !== 1'b1 || resp_id !== g || result !== er || zero !== ez ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL hold: valid=%b id=%b result=%h zero=%b rdy=%b%b want 1 %b %h %b 00",
                         resp_valid, resp_id, result, zero, req0_ready, req1_ready, g, er, ez);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        compared++;
        if ({req0_ready, req1_ready, resp_valid} !== 3'b001) begin
            mismatched++;
            $display("FAIL handshake: rdy0/rdy1/resp_valid got %b%b%b want 001",
                     req0_ready, req1_ready, resp_valid);
        end
        @(posedge clk); #1;
        compared++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL release: resp_valid=%b busy=%b want 0 0", resp_valid, busy);
        end
        resp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'd0; req1_op = 2'd0;
        req0_a = 16'h1; req0_b = 16'h1; req1_a = 16'h2; req1_b = 16'h2;
        exp_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, zero, busy} !== 6'b0 || result !== 16'h0) begin
            mismatched++;
            $display("FAIL reset: rdy=%b%b valid=%b id=%b zero=%b busy=%b result=%h want all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, zero, busy, result);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_no_req();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({req0_ready, req1_ready, busy, resp_valid} !== 4'b0) begin
                mismatched++;
                $display("FAIL idle: rdy=%b%b busy=%b resp_valid=%b want 0000",
                         req0_ready, req1_ready, busy, resp_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        do_txn(1'b1, 2'd0, 16'h0003, 16'h0004, 1'b0, 2'd0, 16'h0, 16'h0, 0);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 2'd1, 16'h0005, 16'h0005, 1'b1, 2'd3, 16'h00F0, 16'h000F, 0);
    endtask

    task automatic test_wrap();
        do_txn(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd0, 16'hFFFF, 16'h0001, 0);
        do_txn(1'b1, 2'd1, 16'h0000, 16'h0001, 1'b0, 2'd0, 16'h0, 16'h0, 0);
    endtask

    task automatic test_stall();
        do_txn(1'b1, 2'd2, 16'hA5A5, 16'h0FF0, 1'b1, 2'd0, 16'h1111, 16'h2222, 5);
        do_txn(1'b1, 2'd3, 16'h0101, 16'h1010, 1'b1, 2'd1, 16'h0010, 16'h0001, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic        v0, v1;
            logic [1:0]  o0, o1;
            logic [15:0] a0, b0, a1, b1;
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            o0 = 2'($urandom); o1 = 2'($urandom);
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b0 = a0;
            if ($urandom_range(0, 3) == 0) b1 = 16'h0 - a1;
            do_txn(v0, o0, a0, b0, v1, o1, a1, b1, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_abort();
        req0_valid = 1'b0; req1_valid = 1'b1;
        req1_op = 2'd2; req1_a = 16'h1234; req1_b = 16'h00FF;
        resp_ready = 1'b1;
        @(negedge clk);
        compared++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL abort_grant: rdy=%b%b want 01", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, zero, busy} !== 6'b0 || result !== 16'h0) begin
            mismatched++;
            $display("FAIL abort: rdy=%b%b valid=%b id=%b zero=%b busy=%b result=%h want all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, zero, busy, result);
        end
        @(posedge clk); #1;
        compared++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_hold: resp_valid=%b busy=%b want 0 0", resp_valid, busy);
        end
        @(negedge clk); rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        exp_last = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b1, 2'd0, 16'h0010, 16'h0020, 1'b1, 2'd0, 16'h0030, 16'h0040, 0);
    endtask

    initial begin
        test_reset();
        test_idle_no_req();
        test_basic();
        test_alternate();
        test_wrap();
        test_stall();
        test_random();
        test_reset_abort();
        test_idle_no_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
